// File: rtl/rr_pkt_mux.sv
// Packet-aware N-channel multiplexer with round-robin or fixed-priority arbitration.
// A granted multi-beat packet locks the mux to its channel until the last beat passes.
// The output is a single register stage: one cycle of latency, full throughput.
module rr_pkt_mux #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CH       = 16,
  parameter int unsigned MODE       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH-1:0]            in_last,
  output logic [N_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(N_CH)-1:0]    out_sel,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned SEL_WIDTH = $clog2(N_CH);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e                 state_q;
  logic [SEL_WIDTH-1:0]   rr_ptr_q;
  logic [SEL_WIDTH-1:0]   lock_ch_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [SEL_WIDTH-1:0]   out_sel_q;
  logic                   out_last_q;
  logic                   out_valid_q;

  logic                   load_en;
  logic [N_CH-1:0]        eligible;
  logic                   grant_vld;
  logic [SEL_WIDTH-1:0]   grant_idx;
  logic [SEL_WIDTH-1:0]   cand;
  int unsigned            idx;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_last;
  logic                   hs;

  // The output register can accept a new beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // While locked only the packet owner may compete.
  always_comb begin
    eligible = in_valid;
    if (state_q == StLock) begin
      eligible = '0;
      eligible[lock_ch_q] = in_valid[lock_ch_q];
    end
  end

  // Pick the first eligible channel, scanning upward from rr_ptr (MODE 0) or from 0 (MODE 1).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (MODE == 0) begin
        idx = 32'(rr_ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
      end else begin
        idx = i;
      end
      cand = SEL_WIDTH'(idx);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Route the winner's payload and last flag toward the output register.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant_idx == SEL_WIDTH'(k)) sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_last = in_last[grant_idx];
  end

  // One-hot accept to the winner, suppressed when the output is stalled or in reset.
  always_comb begin
    in_ready = '0;
    if (!rst && load_en && grant_vld) in_ready[grant_idx] = 1'b1;
  end

  assign hs = load_en && grant_vld;

  // Output register, packet lock FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= hs;
      if (hs) begin
        out_data_q <= sel_data;
        out_sel_q  <= grant_idx;
        out_last_q <= sel_last;
        if (sel_last) begin
          state_q <= StIdle;
          if (MODE == 0) begin
            rr_ptr_q <= (grant_idx == SEL_WIDTH'(N_CH - 1)) ? '0 : grant_idx + SEL_WIDTH'(1);
          end
        end else begin
          state_q   <= StLock;
          lock_ch_q <= grant_idx;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_pkt_mux.sv
// Directed bench for rr_pkt_mux: one round-robin and one fixed-priority instance share stimulus.
module tb_rr_pkt_mux;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]  in_valid;
  logic [NC-1:0]  in_last;
  logic           out_ready;

  logic [NC-1:0]  in_ready0, in_ready1;
  logic [DW-1:0]  out_data0, out_data1;
  logic [3:0]     out_sel0, out_sel1;
  logic           out_last0, out_last1;
  logic           out_valid0, out_valid1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_pkt_mux #(.DATA_WIDTH(DW), .N_CH(NC), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready0), .out_data(out_data0), .out_sel(out_sel0), .out_last(out_last0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  rr_pkt_mux #(.DATA_WIDTH(DW), .N_CH(NC), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1), .out_last(out_last1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  function automatic logic [31:0] payload(int k);
    return 32'h1000_0000 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '1;
    out_ready = 1'b1;
    for (int k = 0; k < NC; k++) in_data[k*DW +: DW] = payload(k);
    step();
    step();

    // Reset state, with all channels requesting during reset.
    in_valid = 16'hFFFF;
    #1;
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_out_data",  64'(out_data0),  64'd0);
    check("rst_out_sel",   64'(out_sel0),   64'd0);
    check("rst_out_last",  64'(out_last0),  64'd0);
    check("rst_in_ready",  64'(in_ready0),  64'd0);
    check("rst_in_ready_m1", 64'(in_ready1), 64'd0);

    // Round-robin sweep across all channels, single-beat packets, no bubbles.
    rst = 1'b0;
    #1;
    check("rr_first_ready", 64'(in_ready0), 64'h0001);
    for (int i = 0; i < 17; i++) begin
      step();
      check("rr_valid", 64'(out_valid0), 64'd1);
      check("rr_sel",   64'(out_sel0),   64'(i % 16));
      check("rr_data",  64'(out_data0),  64'(payload(i % 16)));
      check("rr_ready", 64'(in_ready0),  64'(16'(1) << ((i + 1) % 16)));
    end
    in_valid = '0;
    step();
    check("rr_drain_valid", 64'(out_valid0), 64'd0);

    // Fixed priority: channel 3 always beats channel 5.
    pulse_reset();
    in_valid = 16'h0028;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fp_ready", 64'(in_ready1), 64'h0008);
      step();
      check("fp_sel",   64'(out_sel1),   64'd3);
      check("fp_valid", 64'(out_valid1), 64'd1);
    end
    in_valid = '0;
    step();

    // Channel 2 three-beat packet while channel 7 waits.
    pulse_reset();
    in_valid = 16'h0084;
    in_last  = 16'hFFFB;
    #1;
    check("lock_ready0", 64'(in_ready0), 64'h0004);
    step();
    check("lock_sel1",  64'(out_sel0),  64'd2);
    check("lock_last1", 64'(out_last0), 64'd0);
    check("lock_ready1", 64'(in_ready0), 64'h0004);
    step();
    check("lock_sel2",  64'(out_sel0),  64'd2);
    in_last = 16'hFFFF;
    #1;
    check("lock_ready2", 64'(in_ready0), 64'h0004);
    step();
    check("lock_sel3",  64'(out_sel0),  64'd2);
    check("lock_last3", 64'(out_last0), 64'd1);
    check("lock_ready3", 64'(in_ready0), 64'h0080);
    in_data[7*DW +: DW] = 32'hDEADBEEF;
    step();
    check("after_lock_sel", 64'(out_sel0), 64'd7);

    // Stall with DEADBEEF held, then release with no bubble.
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_ready", 64'(in_ready0), 64'd0);
      step();
      check("stall_data",  64'(out_data0),  64'hDEADBEEF);
      check("stall_sel",   64'(out_sel0),   64'd7);
      check("stall_valid", 64'(out_valid0), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready0), 64'h0004);
    step();
    check("release_valid", 64'(out_valid0), 64'd1);
    check("release_sel",   64'(out_sel0),   64'd2);
    check("release_data",  64'(out_data0),  64'(payload(2)));
    in_data[7*DW +: DW] = payload(7);

    // Reset mid-packet on channel 4 with rr_ptr at 9.
    in_valid = '0;
    pulse_reset();
    in_valid = 16'h0100;
    step();
    check("ptr9_sel", 64'(out_sel0), 64'd8);
    in_valid = 16'h0010;
    in_last  = 16'hFFEF;
    #1;
    check("ch4_ready", 64'(in_ready0), 64'h0010);
    step();
    check("ch4_sel", 64'(out_sel0), 64'd4);
    in_valid = 16'h0210;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(in_ready0), 64'd0);
    step();
    rst = 1'b0;
    in_valid = 16'h0200;
    #1;
    check("midrst_valid", 64'(out_valid0), 64'd0);
    check("midrst_idle",  64'(in_ready0),  64'h0200);
    in_valid = 16'h0210;
    in_last  = 16'hFFFF;
    #1;
    check("midrst_ready_ptr0", 64'(in_ready0), 64'h0010);
    step();
    check("midrst_sel",   64'(out_sel0),   64'd4);
    check("single_valid", 64'(out_valid0), 64'd1);

    // Single beat then idle: out_valid for exactly one cycle.
    in_valid = '0;
    step();
    check("single_drop", 64'(out_valid0), 64'd0);
    step();
    check("single_stay", 64'(out_valid0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
